// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: fetch/decode/exec/mem/wb stepping with a
// memory-wait timeout that parks the block in HALT until reset.
//
//   state  | meaning
//   FETCH  | instruction read; IR and PC load when memory answers
//   DECODE | class decode; jumps retire here, illegal ops halt
//   EXEC   | branch resolve, or dispatch to MEM / WB
//   MEM    | data read or write, waits on mem_ready
//   WB     | register-file write, retire
//   HALT   | timeout or illegal op; left only through rst
module mc_ctrl_fsm #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IRWr,
  output logic        PCWr,
  output logic        RFWr,
  output logic        instr_done,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'(MAX_WAIT - 1);

  state_t         st_q, st_nxt;
  logic [WCW-1:0] wcnt;
  logic           wait_inc;

  logic is_jr, is_jalr, is_r, is_i, is_ld, is_st, is_br, is_j, is_jal, is_legal;

  always_comb begin
    is_jr    = (op == 6'h00) && (funct == 6'h08);
    is_jalr  = (op == 6'h00) && (funct == 6'h09);
    is_r     = (op == 6'h00) && !is_jr && !is_jalr;
    is_i     = (op[5:3] == 3'b001);
    is_ld    = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    is_st    = op inside {6'h28, 6'h29, 6'h2B};
    is_br    = op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
    is_j     = (op == 6'h02) || is_jr;
    is_jal   = (op == 6'h03) || is_jalr;
    is_legal = is_r || is_i || is_ld || is_st || is_br || is_j || is_jal;
  end

  always_comb begin
    st_nxt     = st_q;
    wait_inc   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    RFWr       = 1'b0;
    instr_done = 1'b0;
    case (st_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          st_nxt = S_DECODE;
        end else if (wcnt == WLIM) begin
          st_nxt = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          PCWr       = 1'b1;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end else if (is_jal) begin
          PCWr       = 1'b1;
          RFWr       = 1'b1;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end else if (!is_legal) begin
          st_nxt = S_HALT;
        end else begin
          st_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          PCWr       = br_cond;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end else if (is_ld || is_st) begin
          st_nxt = S_MEM;
        end else if (is_r || is_i) begin
          st_nxt = S_WB;
        end else begin
          // op is stable from DECODE, so this only catches a misbehaving datapath
          st_nxt = S_HALT;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        if (mem_ready) begin
          instr_done = is_st;
          st_nxt     = is_st ? S_FETCH : S_WB;
        end else if (wcnt == WLIM) begin
          st_nxt = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        RFWr       = 1'b1;
        instr_done = 1'b1;
        st_nxt     = S_FETCH;
      end
      S_HALT:  st_nxt = S_HALT;
      default: st_nxt = S_HALT;
    endcase

    // reset masks every strobe so an aborted instruction never retires
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      IRWr       = 1'b0;
      PCWr       = 1'b0;
      RFWr       = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_FETCH;
      wcnt    <= '0;
      retired <= '0;
    end else begin
      st_q    <= st_nxt;
      retired <= retired + 32'(instr_done);
      if (st_nxt != st_q)
        wcnt <= '0;
      else if (wait_inc)
        wcnt <= wcnt + 1'b1;
    end
  end

  assign state  = st_q;
  assign halted = (st_q == S_HALT) && !rst;

endmodule
